// File: rtl/rle_row_decompressor_if.sv
// Byte-in / pixel-out handshake bundle for rle_row_decompressor.
// slave is the decoder side, master is the FIFO/VGA side.
interface rle_row_decompressor_if #(
    parameter int PixelSize = 16
);
    logic [7:0]           i_byte;
    logic                 i_valid;
    logic                 o_byte_ready;
    logic [PixelSize-1:0] o_pixel;
    logic                 o_valid;
    logic                 i_pixel_ready;
    logic                 o_last;
    logic                 o_error;

    modport slave (
        input  i_byte, i_valid, i_pixel_ready,
        output o_byte_ready, o_pixel, o_valid, o_last, o_error
    );

    modport master (
        output i_byte, i_valid, i_pixel_ready,
        input  o_byte_ready, o_pixel, o_valid, o_last, o_error
    );
endinterface

// File: rtl/rle_row_decompressor.sv
// Expands a YUV422 row RLE byte stream into {Y,C} pixels.
// Optional sync/phase checking: define RLE_DECOMP_ERRCHK_EN.
module rle_row_decompressor #(
    parameter int RowPixelWidth = 640,
    parameter int PixelSize     = 16
) (
    input logic                   CLK,
    input logic                   RST,
    rle_row_decompressor_if.slave bus
);
    localparam int CW = $clog2(RowPixelWidth);

    typedef enum logic {S_TAG, S_VAL} state_t;

    state_t        r_state;
    logic [7:0]    r_tag;
    logic [7:0]    r_yv, r_uv, r_vv;
    logic [6:0]    r_yc, r_uc, r_vc;
    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic [15:0]   r_pixel;
    logic          r_valid;
    logic          r_last;

    logic [1:0] w_ch;
    logic [6:0] w_len;
    logic       w_c_ok;
    logic [7:0] w_c_val;
    logic       w_emit;
    logic       w_wrap;
    logic       w_empty;
    logic       w_ready;
    logic       w_load;
    logic       w_err;

    assign w_ch    = r_tag[7:6];
    assign w_len   = {1'b0, r_tag[5:0]} + 7'd1;
    assign w_c_ok  = r_phase ? (r_vc != 7'd0) : (r_uc != 7'd0);
    assign w_c_val = r_phase ? r_vv : r_uv;
    assign w_emit  = (!r_valid || bus.i_pixel_ready)
                     && (r_yc != 7'd0) && w_c_ok;
    assign w_wrap  = (r_cnt == CW'(RowPixelWidth - 1));

    // All runs empty already rules out an emission, so sync needs no emit term.
    always_comb begin
        w_empty = 1'b0;
        unique case (w_ch)
            2'b00: w_empty = (r_yc == 7'd0);
            2'b01: w_empty = (r_uc == 7'd0);
            2'b10: w_empty = (r_vc == 7'd0);
            2'b11: w_empty = (r_yc == 7'd0) && (r_uc == 7'd0)
                             && (r_vc == 7'd0);
        endcase
    end

    assign w_ready = (r_state == S_TAG) || w_empty;
    assign w_load  = (r_state == S_VAL) && bus.i_valid && w_empty;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_TAG;
            r_tag   <= 8'd0;
            r_yv    <= 8'd0;
            r_uv    <= 8'd0;
            r_vv    <= 8'd0;
            r_yc    <= 7'd0;
            r_uc    <= 7'd0;
            r_vc    <= 7'd0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_pixel <= 16'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                S_TAG: if (bus.i_valid) begin
                    r_tag   <= bus.i_byte;
                    r_state <= S_VAL;
                end
                S_VAL: if (w_load) r_state <= S_TAG;
            endcase

            if (w_emit) begin
                r_pixel <= {r_yv, w_c_val};
                r_valid <= 1'b1;
                r_last  <= w_wrap;
                r_yc    <= r_yc - 7'd1;
                if (r_phase) r_vc <= r_vc - 7'd1;
                else         r_uc <= r_uc - 7'd1;
                r_phase <= w_wrap ? 1'b0 : ~r_phase;
                r_cnt   <= w_wrap ? '0 : r_cnt + 1'b1;
            end else if (bus.i_pixel_ready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            // Loads only hit empty runs, so they never collide with a decrement.
            if (w_load) begin
                unique case (w_ch)
                    2'b00: begin r_yv <= bus.i_byte; r_yc <= w_len; end
                    2'b01: begin r_uv <= bus.i_byte; r_uc <= w_len; end
                    2'b10: begin r_vv <= bus.i_byte; r_vc <= w_len; end
                    2'b11: begin r_cnt <= '0; r_phase <= 1'b0; end
                endcase
            end
        end
    end

`ifdef RLE_DECOMP_ERRCHK_EN
    logic r_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_load && (
                       ((w_ch == 2'b11) && (r_cnt != '0)) ||
                       ((w_ch == 2'b01) && r_phase && (r_vc != 7'd0)));
        end
    end

    assign w_err = r_err;
`else
    assign w_err = 1'b0;
`endif

    assign bus.o_byte_ready = w_ready;
    assign bus.o_pixel      = r_pixel[PixelSize-1:0];
    assign bus.o_valid      = r_valid;
    assign bus.o_last       = r_last;
    assign bus.o_error      = w_err;
endmodule

// File: tb/tb_rle_row_decompressor.sv
// Directed bench for rle_row_decompressor: vector table plus
// hand-written backpressure, stall, full-row, sync and reset sequences.
module tb_rle_row_decompressor;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    rle_row_decompressor_if #(.PixelSize(16)) bus();

    rle_row_decompressor #(
        .RowPixelWidth(640),
        .PixelSize(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int              nb;
        logic [0:7][7:0] b;
        int              np;
        logic [0:3][15:0] px;
    } vec_t;

    vec_t        vt[5];
    int          checks = 0;
    int          errors = 0;
    int          err_cnt = 0;
    logic [16:0] q[$];

`ifdef RLE_DECOMP_ERRCHK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    always @(negedge CLK) begin
        if (!RST && bus.o_valid && bus.i_pixel_ready)
            q.push_back({bus.o_last, bus.o_pixel});
        if (bus.o_error) err_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        logic rdy;
        int   n;
        bus.i_byte  = b;
        bus.i_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge CLK);
            rdy = bus.o_byte_ready;
            @(posedge CLK);
            #1;
            if (rdy) break;
            n++;
            if (n > 3000) begin
                check("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic rec(input logic [7:0] tag, input logic [7:0] val);
        send(tag);
        send(val);
    endtask

    task automatic wait_pix(input string nm, input int n);
        int k = 0;
        while (q.size() < n && k < 2000) begin
            tick();
            k++;
        end
        repeat (4) tick();
        check(nm, 32'(q.size()), 32'(n));
    endtask

    initial begin
        vt[0].nb = 6;
        vt[0].b  = {8'h03, 8'h10, 8'h41, 8'h80, 8'h81, 8'h90, 8'h00, 8'h00};
        vt[0].np = 4;
        vt[0].px = {16'h1080, 16'h1090, 16'h1080, 16'h1090};
        vt[1].nb = 4;
        vt[1].b  = {8'h00, 8'h33, 8'h40, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
        vt[1].np = 1;
        vt[1].px = {16'h3344, 16'h0, 16'h0, 16'h0};
        vt[2].nb = 6;
        vt[2].b  = {8'h01, 8'hA0, 8'h40, 8'h11, 8'h80, 8'h22, 8'h00, 8'h00};
        vt[2].np = 2;
        vt[2].px = {16'hA011, 16'hA022, 16'h0, 16'h0};
        vt[3].nb = 6;
        vt[3].b  = {8'h02, 8'h55, 8'h41, 8'h01, 8'h80, 8'h02, 8'h00, 8'h00};
        vt[3].np = 3;
        vt[3].px = {16'h5501, 16'h5502, 16'h5501, 16'h0};
        vt[4].nb = 8;
        vt[4].b  = {8'h00, 8'h7F, 8'h40, 8'hC0, 8'h00, 8'h80, 8'h80, 8'hD0};
        vt[4].np = 2;
        vt[4].px = {16'h7FC0, 16'h80D0, 16'h0, 16'h0};

        bus.i_byte        = 8'h00;
        bus.i_valid       = 1'b0;
        bus.i_pixel_ready = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_pixel", 32'(bus.o_pixel), 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_last", 32'(bus.o_last), 32'h0);
        check("rst_error", 32'(bus.o_error), 32'h0);
        check("rst_byte_ready", 32'(bus.o_byte_ready), 32'h1);
        tick();

        for (int v = 0; v < 5; v++) begin
            q.delete();
            for (int i = 0; i < vt[v].nb; i++) send(vt[v].b[i]);
            rec(8'hC0, 8'h00);
            wait_pix($sformatf("vec%0d_count", v), vt[v].np);
            for (int i = 0; i < vt[v].np; i++)
                check($sformatf("vec%0d_pix%0d", v, i),
                      32'(q[i]), {15'd0, 1'b0, vt[v].px[i]});
        end

        q.delete();
        bus.i_pixel_ready = 1'b0;
        rec(8'h03, 8'h10);
        rec(8'h41, 8'h80);
        rec(8'h81, 8'h90);
        repeat (3) begin
            @(negedge CLK);
            check("bp_hold", 32'({bus.o_valid, bus.o_pixel}), 32'h11080);
        end
        tick();
        bus.i_pixel_ready = 1'b1;
        rec(8'hC0, 8'h00);
        wait_pix("bp_count", 4);
        check("bp_pix0", 32'(q[0]), 32'h1080);
        check("bp_pix1", 32'(q[1]), 32'h1090);
        check("bp_pix2", 32'(q[2]), 32'h1080);
        check("bp_pix3", 32'(q[3]), 32'h1090);

        q.delete();
        bus.i_pixel_ready = 1'b0;
        rec(8'h03, 8'h10);
        rec(8'h42, 8'h80);
        rec(8'h82, 8'h90);
        send(8'h01);
        bus.i_byte  = 8'h20;
        bus.i_valid = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("stall_byte_ready", 32'(bus.o_byte_ready), 32'h0);
        end
        tick();
        bus.i_pixel_ready = 1'b1;
        send(8'h20);
        rec(8'hC0, 8'h00);
        wait_pix("stall_count", 6);
        check("stall_pix0", 32'(q[0]), 32'h1080);
        check("stall_pix1", 32'(q[1]), 32'h1090);
        check("stall_pix2", 32'(q[2]), 32'h1080);
        check("stall_pix3", 32'(q[3]), 32'h1090);
        check("stall_pix4", 32'(q[4]), 32'h2080);
        check("stall_pix5", 32'(q[5]), 32'h2090);

        q.delete();
        rec(8'h02, 8'h10);
        rec(8'h41, 8'h80);
        rec(8'h80, 8'h90);
        wait_pix("sync_pre_count", 3);
        check("sync_pre_pix0", 32'(q[0]), 32'h1080);
        check("sync_pre_pix1", 32'(q[1]), 32'h1090);
        check("sync_pre_pix2", 32'(q[2]), 32'h1080);
        begin
            int e0;
            e0 = err_cnt;
            rec(8'hC0, 8'h00);
            repeat (3) tick();
            check("sync_error_pulses", 32'(err_cnt - e0), 32'(ERR_EXP));
        end
        rec(8'h00, 8'h33);
        rec(8'h40, 8'h44);
        wait_pix("sync_post_count", 4);
        check("sync_post_pix", 32'(q[3]), 32'h3344);
        rec(8'hC0, 8'h00);

        q.delete();
        for (int k = 0; k < 10; k++) begin
            rec(8'h3F, 8'(k));
            if (k % 2 == 0) begin
                rec(8'h7F, 8'(8'h80 + k / 2));
                rec(8'hBF, 8'(8'hA0 + k / 2));
            end
        end
        wait_pix("row_count", 640);
        for (int p = 0; p < 640; p++) begin
            logic [7:0] ey, ec;
            ey = 8'(p / 64);
            ec = (p % 2 == 0) ? 8'(8'h80 + p / 128) : 8'(8'hA0 + p / 128);
            check($sformatf("row_pix%0d", p), 32'(q[p]),
                  {15'd0, (p == 639), ey, ec});
        end
        rec(8'h00, 8'h33);
        rec(8'h40, 8'h44);
        wait_pix("row_next_count", 641);
        check("row_next_pix", 32'(q[640]), 32'h3344);
        rec(8'hC0, 8'h00);

        q.delete();
        bus.i_pixel_ready = 1'b0;
        rec(8'h01, 8'h55);
        rec(8'h41, 8'h66);
        send(8'h03);
        repeat (2) tick();
        @(negedge CLK);
        check("mid_pre_valid", 32'({bus.o_valid, bus.o_pixel}), 32'h15566);
        check("mid_pre_byte_ready", 32'(bus.o_byte_ready), 32'h0);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        check("mid_rst_pixel", 32'(bus.o_pixel), 32'h0);
        check("mid_rst_valid", 32'(bus.o_valid), 32'h0);
        check("mid_rst_last", 32'(bus.o_last), 32'h0);
        check("mid_rst_error", 32'(bus.o_error), 32'h0);
        check("mid_rst_byte_ready", 32'(bus.o_byte_ready), 32'h1);
        tick();
        bus.i_pixel_ready = 1'b1;
        rec(8'h00, 8'h33);
        rec(8'h40, 8'h44);
        wait_pix("mid_post_count", 1);
        check("mid_post_pix", 32'(q[0]), 32'h3344);

`ifndef RLE_DECOMP_ERRCHK_EN
        check("no_error_pulses", 32'(err_cnt), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
